mresc_wrapper_sobel3x3_x_8b_g2: RTL and testbench

- Stochastic-computing (ReSC-style) evaluator of a 3x3 Sobel gradient magnitude along one axis.
- Takes six 8-bit pixel values, three on the "positive" side of the centre pixel and three on the "negative" side.
- Converts them to correlated bitstreams and forms a weighted absolute difference over a 256-cycle stream.
- Returns the popcount as an 8-bit binary result. Two instances, one per axis, feed an edge-magnitude stage.

---
 rtl/mresc_wrapper_sobel3x3_x_8b_g2.sv | 94 +++++++++
 tb/tb_mresc_wrapper_sobel3x3_x_8b_g2.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mresc_wrapper_sobel3x3_x_8b_g2.sv
// ReSC-style stochastic evaluator of a 3x3 Sobel axis gradient |x1-x4| + 2|x2-x5| + |x3-x6| over a 2**N_BITS-cycle stream.
// Optional MRESC_LFSR_RESEED_EN: reload the LFSR on every start cycle so results repeat per pixel.
module mresc_wrapper_sobel3x3_x_8b_g2 #(
   parameter int unsigned          N_BITS    = 8,
   parameter logic [N_BITS-1:0]    LFSR_SEED = 8'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_BITS-1:0] x_1_bin,
   input  logic [N_BITS-1:0] x_2_bin,
   input  logic [N_BITS-1:0] x_3_bin,
   input  logic [N_BITS-1:0] x_4_bin,
   input  logic [N_BITS-1:0] x_5_bin,
   input  logic [N_BITS-1:0] x_6_bin,
   output logic [N_BITS-1:0] z_bin,
   output logic              done
);

   logic [N_BITS-1:0] lfsr_q, lfsr_d;
   logic [N_BITS-1:0] cnt_q, cnt_d;
   logic [N_BITS:0]   acc_q, acc_d;
   logic [N_BITS-1:0] z_q, z_d;
   logic              done_q, done_d;

   logic [5:0]        bits;
   logic              top_bit, bot_bit, o_bit;
   logic [N_BITS:0]   acc_inc;
   logic [N_BITS-1:0] lfsr_next;

   always_comb begin
      bits[0] = lfsr_q < x_1_bin;
      bits[1] = lfsr_q < x_2_bin;
      bits[2] = lfsr_q < x_3_bin;
      bits[3] = lfsr_q < x_4_bin;
      bits[4] = lfsr_q < x_5_bin;
      bits[5] = lfsr_q < x_6_bin;

      // Middle pair takes two of every four slots, giving it weight 1/2.
      case (cnt_q[1:0])
         2'd0:    begin top_bit = bits[0]; bot_bit = bits[3]; end
         2'd3:    begin top_bit = bits[2]; bot_bit = bits[5]; end
         default: begin top_bit = bits[1]; bot_bit = bits[4]; end
      endcase
      o_bit   = top_bit ^ bot_bit;
      acc_inc = acc_q + (N_BITS+1)'(o_bit);

      lfsr_next = {lfsr_q[N_BITS-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_comb begin
      lfsr_d = lfsr_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      z_d    = z_q;
      done_d = done_q;
      if (start) begin
         cnt_d  = '0;
         acc_d  = '0;
         done_d = 1'b0;
`ifdef MRESC_LFSR_RESEED_EN
         lfsr_d = LFSR_SEED;
`endif
      end else if (!done_q) begin
         lfsr_d = lfsr_next;
         cnt_d  = cnt_q + N_BITS'(1);
         acc_d  = acc_inc;
         if (cnt_q == '1) begin
            done_d = 1'b1;
            z_d    = acc_inc[N_BITS] ? '1 : acc_inc[N_BITS-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= LFSR_SEED;
         cnt_q  <= '0;
         acc_q  <= '0;
         z_q    <= '0;
         done_q <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         z_q    <= z_d;
         done_q <= done_d;
      end
   end

   assign z_bin = z_q;
   assign done  = done_q;

endmodule

// File: tb/tb_mresc_wrapper_sobel3x3_x_8b_g2.sv
// Directed bench for mresc_wrapper_sobel3x3_x_8b_g2: stream-level reference model plus hand-computed pins.
module tb_mresc_wrapper_sobel3x3_x_8b_g2;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b1;
   logic [7:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0, x5 = '0, x6 = '0;
   logic [7:0] z_bin;
   logic       done;

   int errors = 0;
   int checks = 0;

   mresc_wrapper_sobel3x3_x_8b_g2 #(.N_BITS(8), .LFSR_SEED(8'hFF)) dut (
      .clk(clk), .reset(reset), .start(start),
      .x_1_bin(x1), .x_2_bin(x2), .x_3_bin(x3),
      .x_4_bin(x4), .x_5_bin(x5), .x_6_bin(x6),
      .z_bin(z_bin), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] lfsr_step(input logic [7:0] r);
      return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
   endfunction

   // Whole-stream evaluation: popcount of the weighted XOR stream, saturated to 8 bits.
   function automatic logic [7:0] sobel_stream(input logic [7:0] seed,
         input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
         input logic [7:0] a4, input logic [7:0] a5, input logic [7:0] a6);
      logic [7:0] r;
      int acc;
      bit t, b;
      r = seed;
      acc = 0;
      for (int i = 0; i < 256; i++) begin
         case (i % 4)
            0:       begin t = (r < a1); b = (r < a4); end
            3:       begin t = (r < a3); b = (r < a6); end
            default: begin t = (r < a2); b = (r < a5); end
         endcase
         acc += int'(t ^ b);
         r = lfsr_step(r);
      end
      return (acc > 255) ? 8'd255 : acc[7:0];
   endfunction

   logic [7:0] m_lfsr = 8'hFF;
   logic [7:0] m_snap = 8'hFF;
   logic [7:0] m_z    = 8'h00;
   logic       m_done = 1'b0;
   int         m_runs = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_lfsr = 8'hFF; m_z = 8'h00; m_done = 1'b0; m_runs = 0;
      end else if (start) begin
         m_runs = 0; m_done = 1'b0;
`ifdef MRESC_LFSR_RESEED_EN
         m_lfsr = 8'hFF;
`endif
      end else if (!m_done) begin
         if (m_runs == 0) m_snap = m_lfsr;
         m_runs++;
         m_lfsr = lfsr_step(m_lfsr);
         if (m_runs == 256) begin
            m_z = sobel_stream(m_snap, x1, x2, x3, x4, x5, x6);
            m_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if (done !== m_done) begin
         errors++;
         $display("FAIL model_done t=%0t actual=%b required=%b", $time, done, m_done);
      end
      checks++;
      if (z_bin !== m_z) begin
         errors++;
         $display("FAIL model_z t=%0t actual=%0d required=%0d", $time, z_bin, m_z);
      end
   end

   task automatic check(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic check_range(input string name, input int actual, input int lo, input int hi);
      checks++;
      if (actual < lo || actual > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_px(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                         input logic [7:0] a4, input logic [7:0] a5, input logic [7:0] a6);
      x1 = a1; x2 = a2; x3 = a3; x4 = a4; x5 = a5; x6 = a6;
   endtask

   task automatic pulse_start(input int n);
      start = 1'b1;
      repeat (n) step();
   endtask

   // Lower start and count edges until done; an expired bound reports as a failure.
   task automatic run(input string name, output int edges);
      start = 1'b0;
      edges = 0;
      while (done !== 1'b1 && edges < 300) begin
         step();
         edges++;
      end
      check({name, "_latency"}, edges, 256);
   endtask

   int n;
   int z_a, z_b, z_keep;

   initial begin
      repeat (3) step();
      reset = 1'b1;
      step();
      check("reset_z", z_bin, 0);
      check("reset_done", done, 0);

      // LFSR from seed 0xFF: r==255 appears only at stream positions 0 and 255.
      set_px(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      run("sat", n);
      check("sat_literal", z_bin, 254);
      check_range("sat_floor", z_bin, 250, 255);

      pulse_start(2);
      set_px(8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
      run("flat", n);
      check("flat_zero", z_bin, 0);
      repeat (10) step();
      check("flat_hold_done", done, 1);
      check("flat_hold_z", z_bin, 0);

      pulse_start(2);
      set_px(8'd17, 8'd99, 8'd200, 8'd17, 8'd99, 8'd200);
      run("pairs_eq", n);
      check("pairs_eq_zero", z_bin, 0);

      pulse_start(2);
      set_px(8'd0, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0);
      run("x2", n);
      z_a = z_bin;
      check_range("x2_range", z_a, 52, 76);

      pulse_start(2);
      set_px(8'd0, 8'd0, 8'd0, 8'd0, 8'd128, 8'd0);
      run("x5", n);
      z_b = z_bin;
      check_range("x5_range", z_b, 52, 76);
`ifdef MRESC_LFSR_RESEED_EN
      check("swap_same", z_b, z_a);
`endif

      pulse_start(2);
      set_px(8'd0, 8'd128, 8'd0, 8'd0, 8'd0, 8'd0);
      run("x2_again", n);
`ifdef MRESC_LFSR_RESEED_EN
      check("repeat_identical", z_bin, z_a);
`else
      check_range("x2_again_range", z_bin, 52, 76);
`endif

      // Abort at cycle 100.
      z_keep = z_bin;
      pulse_start(2);
      set_px(8'd200, 8'd50, 8'd30, 8'd10, 8'd150, 8'd90);
      start = 1'b0;
      repeat (100) step();
      check("abort_mid_done", done, 0);
      pulse_start(1);
      check("abort_done", done, 0);
      check("abort_z_kept", z_bin, z_keep);
      pulse_start(1);
      run("after_abort", n);

      // start raised exactly on the completion edge.
      z_keep = z_bin;
      pulse_start(2);
      set_px(8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
      start = 1'b0;
      repeat (255) step();
      check("collide_pre_done", done, 0);
      pulse_start(1);
      check("collide_done", done, 0);
      check("collide_z_kept", z_bin, z_keep);
      pulse_start(1);
      run("after_collide", n);

      // Async reset mid-run, observed between clock edges.
      pulse_start(2);
      start = 1'b0;
      repeat (50) step();
      #1 reset = 1'b0;
      #1;
      check("async_rst_z", z_bin, 0);
      check("async_rst_done", done, 0);
      step();
      reset = 1'b1;
      pulse_start(2);
      set_px(8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
      run("post_reset", n);
      check("post_reset_literal", z_bin, 254);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
